fetch_unit_q: RTL and testbench

FETCH_UNIT_Q -- requirements
Module: fetch_unit_q

---
 rtl/fetch_unit_q_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit_q.sv | 101 ++++++++++
 tb/tb_fetch_unit_q.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_q_pkg.sv
// Shared constants for the fetch unit: default datapath width and the NOP
// presented to Decode when no instruction is available.
package fetch_unit_q_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue of {pc, instr} pairs; zero-latency head, push/pop same cycle even when full.
// Flush empties the queue in one cycle and wins over push/pop.
module fetch_fifo
    import fetch_unit_q_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [XLEN-1:0]  push_pc,
    input  logic [XLEN-1:0]  push_instr,
    input  logic             pop,
    input  logic             flush,
    output logic [XLEN-1:0]  head_pc,
    output logic [XLEN-1:0]  head_instr,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [XLEN-1:0]  pc_mem_d    [DEPTH];
    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic [XLEN-1:0]  instr_mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                pc_mem_d[wr_ptr_q]    = push_pc;
                instr_mem_d[wr_ptr_q] = push_instr;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end
endmodule

// File: rtl/fetch_unit_q.sv
// Instruction fetch with one outstanding memory request and a DEPTH-entry queue to Decode.
// ValidD rises one cycle after the response; StallD holds the head, a full queue stops requests.
module fetch_unit_q
    import fetch_unit_q_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemValid,
    input  logic [XLEN-1:0] ImemRData,
    output logic            ValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             outst_q, outst_d;
    logic             discard_q, discard_d;
    logic             grant, resp, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [XLEN-1:0]  head_pc, head_instr;

    assign ImemReq  = rst && !outst_q && (fifo_count < CNT_W'(DEPTH));
    assign ImemAddr = pc_q;
    assign grant    = ImemReq && ImemGnt;
    assign resp     = ImemValid && outst_q;
    assign pop      = !fifo_empty && !StallD;
    assign push     = resp && !discard_q && !PCSrcE && (!fifo_full || pop);

    always_comb begin
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        if (grant) begin
            outst_d  = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
        end else if (resp) begin
            outst_d   = 1'b0;
            discard_d = 1'b0;
        end
        // Only a response still in flight after this cycle needs to be dropped.
        if (PCSrcE) begin
            pc_d = {PCTargetE[XLEN-1:2], 2'b00};
            if (grant || (outst_q && !ImemValid)) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            outst_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (req_pc_q),
        .push_instr (ImemRData),
        .pop        (pop),
        .flush      (PCSrcE),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign ValidD   = !fifo_empty;
    assign InstrD   = fifo_empty ? XLEN'(NOP_INSTR) : head_instr;
    assign PCD      = fifo_empty ? '0 : head_pc;
    assign PCPlus4D = fifo_empty ? '0 : head_pc + XLEN'(4);
endmodule

// File: tb/tb_fetch_unit_q.sv
// Bench for fetch_unit_q: directed cycle table, hand sequences and a random memory
// with program-order scoreboard.
module tb_fetch_unit_q;
    import fetch_unit_q_pkg::*;

    logic        clk = 1'b0;
    logic        rst, PCSrcE, StallD, ImemGnt, ImemValid;
    logic [31:0] PCTargetE, ImemRData;
    logic        ImemReq, ValidD;
    logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;

    always #5 clk = ~clk;

    fetch_unit_q #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt), .ImemValid(ImemValid),
        .ImemRData(ImemRData), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst, pcsrc; logic [31:0] tgt; logic stall, gnt, vld; logic [31:0] rdata;
        logic e_req; logic [31:0] e_addr; logic e_vd; logic [31:0] e_pcd, e_instr;
    } vec_t;

    function automatic vec_t v(logic r, logic ps, logic [31:0] tg, logic st, logic g, logic vl,
                               logic [31:0] rd, logic er, logic [31:0] ea, logic ev,
                               logic [31:0] ep, logic [31:0] ei);
        vec_t x;
        x = '{r, ps, tg, st, g, vl, rd, er, ea, ev, ep, ei};
        return x;
    endfunction

    function automatic logic [31:0] mem_fn(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // Reference model: memory side, fetch stream and Decode stream in program order.
    bit          pend, hold, chk_empty, saw_wrap, last_req;
    int          pend_lat, n_grants, n_pops;
    logic [31:0] pend_addr, hold_addr, exp_fetch, exp_pc, last_gaddr;

    task automatic do_reset(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0; PCSrcE = 1'b0; StallD = 1'b0; PCTargetE = $urandom;
            ImemGnt = 1'($urandom); ImemValid = stray; ImemRData = $urandom;
            #1;
            chk("rst_req", ImemReq, 1'b0);
            if (i > 0) begin
                chk("rst_validd", ValidD, 1'b0);
                chk("rst_pcd", PCD, 32'h0);
                chk("rst_instr", InstrD, NOP_INSTR);
            end
            @(posedge clk);
        end
        pend = 0; hold = 0; chk_empty = 0;
        exp_fetch = 32'h0; exp_pc = 32'h0; last_gaddr = 32'h1;
    endtask

    task automatic tick(input bit stall, input bit redir, input logic [31:0] tgt,
                        input int lat_max, input bit stray_en, input bit gnt_rand);
        bit resp;
        @(negedge clk);
        rst = 1'b1; StallD = stall; PCSrcE = redir; PCTargetE = tgt;
        ImemGnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        resp = pend && (pend_lat == 0);
        ImemRData = $urandom;
        ImemValid = 1'b0;
        if (resp) begin
            ImemValid = 1'b1; ImemRData = mem_fn(pend_addr);
        end else if (!pend && stray_en && $urandom_range(0, 7) == 0) begin
            ImemValid = 1'b1;
        end
        #1;
        if (pend) chk("one_outstanding", ImemReq, 1'b0);
        if (hold) begin
            chk("req_hold", ImemReq, 1'b1);
            chk("addr_hold", ImemAddr, hold_addr);
        end
        if (chk_empty) chk("flush_empty", ValidD, 1'b0);
        if (!ValidD) begin
            chk("empty_instr", InstrD, NOP_INSTR);
            chk("empty_pcd", PCD, 32'h0);
            chk("empty_pcp4", PCPlus4D, 32'h0);
        end else begin
            chk("head_pcd", PCD, exp_pc);
            chk("head_instr", InstrD, mem_fn(exp_pc));
            chk("head_pcp4", PCPlus4D, exp_pc + 32'd4);
            if (!stall && !redir) begin
                exp_pc += 32'd4; n_pops++;
            end
        end
        if (resp) pend = 0;
        else if (pend) pend_lat--;
        if (ImemReq && ImemGnt) begin
            chk("fetch_addr", ImemAddr, exp_fetch);
            if (last_gaddr == 32'hFFFF_FFFC && ImemAddr == 32'h0) saw_wrap = 1;
            last_gaddr = ImemAddr;
            pend = 1; pend_addr = ImemAddr; pend_lat = $urandom_range(0, lat_max);
            exp_fetch += 32'd4; n_grants++;
        end
        last_req  = ImemReq;
        hold      = ImemReq && !ImemGnt && !redir;
        hold_addr = ImemAddr;
        chk_empty = redir;
        if (redir) begin
            exp_fetch = {tgt[31:2], 2'b00};
            exp_pc    = {tgt[31:2], 2'b00};
        end
        @(posedge clk);
    endtask

    vec_t tbl[18];
    int   g0, p0, guard;

    initial begin
        rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
        ImemGnt = 1'b0; ImemValid = 1'b0; ImemRData = '0;
        n_grants = 0; n_pops = 0; saw_wrap = 0;

        //            rst ps tgt          st g  vl rdata         req addr         vd pcd          instr
        tbl[0]  = v(0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   NOP_INSTR);
        tbl[1]  = v(1, 0, 32'h0,   0, 1, 0, 32'h0,        1, 32'h0,   0, 32'h0,   NOP_INSTR);
        tbl[2]  = v(1, 0, 32'h0,   0, 1, 1, 32'h1111_0001, 0, 32'h0,  0, 32'h0,   NOP_INSTR);
        tbl[3]  = v(1, 0, 32'h0,   0, 1, 0, 32'h0,        1, 32'h4,   1, 32'h0,   32'h1111_0001);
        tbl[4]  = v(1, 0, 32'h0,   0, 1, 1, 32'h2222_0002, 0, 32'h0,  0, 32'h0,   NOP_INSTR);
        tbl[5]  = v(1, 0, 32'h0,   0, 1, 0, 32'h0,        1, 32'h8,   1, 32'h4,   32'h2222_0002);
        tbl[6]  = v(1, 0, 32'h0,   0, 1, 1, 32'h3333_0003, 0, 32'h0,  0, 32'h0,   NOP_INSTR);
        tbl[7]  = v(1, 0, 32'h0,   1, 0, 0, 32'h0,        1, 32'hC,   1, 32'h8,   32'h3333_0003);
        tbl[8]  = v(1, 0, 32'h0,   1, 0, 0, 32'h0,        1, 32'hC,   1, 32'h8,   32'h3333_0003);
        tbl[9]  = v(1, 1, 32'h203, 0, 0, 0, 32'h0,        1, 32'hC,   1, 32'h8,   32'h3333_0003);
        tbl[10] = v(1, 0, 32'h0,   0, 1, 0, 32'h0,        1, 32'h200, 0, 32'h0,   NOP_INSTR);
        tbl[11] = v(1, 1, 32'h100, 0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   NOP_INSTR);
        tbl[12] = v(1, 0, 32'h0,   0, 1, 1, 32'hDEAD_BEEF, 0, 32'h0,  0, 32'h0,   NOP_INSTR);
        tbl[13] = v(1, 0, 32'h0,   0, 1, 0, 32'h0,        1, 32'h100, 0, 32'h0,   NOP_INSTR);
        tbl[14] = v(1, 0, 32'h0,   0, 0, 1, 32'h4444_0100, 0, 32'h0,  0, 32'h0,   NOP_INSTR);
        tbl[15] = v(1, 0, 32'h0,   1, 0, 0, 32'h0,        1, 32'h104, 1, 32'h100, 32'h4444_0100);
        tbl[16] = v(1, 0, 32'h0,   0, 0, 1, 32'hBAD0_BAD0, 1, 32'h104, 1, 32'h100, 32'h4444_0100);
        tbl[17] = v(1, 0, 32'h0,   0, 0, 0, 32'h0,        1, 32'h104, 0, 32'h0,   NOP_INSTR);

        do_reset(2, 0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; PCSrcE = tbl[i].pcsrc; PCTargetE = tbl[i].tgt;
            StallD = tbl[i].stall; ImemGnt = tbl[i].gnt; ImemValid = tbl[i].vld;
            ImemRData = tbl[i].rdata;
            #1;
            chk($sformatf("t%0d_req", i), ImemReq, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), ImemAddr, tbl[i].e_addr);
            chk($sformatf("t%0d_validd", i), ValidD, tbl[i].e_vd);
            chk($sformatf("t%0d_pcd", i), PCD, tbl[i].e_pcd);
            chk($sformatf("t%0d_pcp4", i), PCPlus4D, tbl[i].e_vd ? tbl[i].e_pcd + 32'd4 : 32'h0);
            chk($sformatf("t%0d_instr", i), InstrD, tbl[i].e_instr);
            @(posedge clk);
        end

        // Decode stalled: exactly DEPTH entries fill, then requests stop; release drains in order.
        do_reset(2, 0);
        g0 = n_grants;
        for (int i = 0; i < 12; i++) tick(1, 0, 32'h0, 0, 0, 0);
        chk("stall_fill_grants", 32'(n_grants - g0), 32'd4);
        chk("stall_req_off", 32'(last_req), 32'd0);
        p0 = n_pops;
        for (int i = 0; i < 20; i++) tick(0, 0, 32'h0, 0, 0, 0);
        chk("stall_release_drained", 32'(n_pops - p0 >= 4), 32'd1);

        // Address wrap past the top of the address space.
        do_reset(2, 0);
        saw_wrap = 0;
        tick(0, 1, 32'hFFFF_FFF8, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(0, 0, 32'h0, 0, 0, 0);
        chk("pc_wrap", 32'(saw_wrap), 32'd1);

        // Reset while a request is outstanding, then stray responses.
        do_reset(2, 0);
        g0 = n_grants;
        guard = 0;
        while (n_grants == g0 && guard < 10) begin
            tick(0, 0, 32'h0, 3, 0, 0);
            guard++;
        end
        chk("rst_mid_grant_seen", 32'(n_grants != g0), 32'd1);
        do_reset(1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1; PCSrcE = 1'b0; StallD = 1'b0; ImemGnt = 1'b0;
            ImemValid = 1'b1; ImemRData = $urandom;
            #1;
            chk("post_rst_validd", ValidD, 1'b0);
            chk("post_rst_req", ImemReq, 1'b1);
            chk("post_rst_addr", ImemAddr, 32'h0);
            @(posedge clk);
        end

        // Random traffic: stalls, grant gaps, variable latency, redirects, stray responses.
        do_reset(2, 0);
        p0 = n_pops;
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom, 3, 1, 1);
        end
        chk("random_progress", 32'(n_pops - p0 > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
